sd_sector_arbiter: RTL and testbench
====================================

Name: sd_sector_arbiter

Overview:
- Core-side stage directly upstream of the SD card wrapper. Four clients share the single sector interface: floppy A/B on slots 0/1, ACSI 0/1 on slots 2/3.
- Arbitrates client read/write requests round-robin and drives the wrapper's rstart/wstart/rsector.
- Routes returned sector bytes to the granted client and muxes that client's write data back.
- Tracks per-slot mount state from the wrapper's image_mounted/image_size reports; fails requests to unmounted slots.

Parameters:
- NUM_CLIENTS, 4, number of client slots; fixed at 4 to match the 4-bit rstart/wstart/image_mounted vectors.
- TIMEOUT_CYCLES, 32'd50_000_000, watchdog limit in clk cycles for one transfer; used only with the optional feature.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- req_rd  in  4  per-client read request; level, held until done
- req_wr  in  4  per-client write request; level, held until done
- req_sector  in  128  per-client sector; client n uses [32n+31:32n]; stable while its request is held
- done  out  4  one-cycle completion pulse per client
- err  out  1  qualifies done: 1 = failed (unmounted or timeout)
- cl_outen  out  4  per-client byte strobe for read data
- cl_outaddr  out  9  byte address, broadcast to all clients
- cl_outbyte  out  8  byte data, broadcast to all clients
- cl_inbyte  in  32  per-client write data; client n uses [8n+7:8n]
- mounted  out  4  current mount flags
- image_mounted  in  4  mount-report pulses from the wrapper
- image_size  in  32  size accompanying the mount report
- rstart  out  4  one-hot read start to the wrapper
- wstart  out  4  one-hot write start to the wrapper
- rsector  out  32  sector to the wrapper
- rbusy  in  1  wrapper busy
- rdone  in  1  wrapper done pulse
- outen  in  1  wrapper byte strobe
- outaddr  in  9  wrapper byte address
- outbyte  in  8  wrapper byte data
- inbyte  out  8  write data to the wrapper

Behaviour:
- Reset values: done=0, err=0, rstart=0, wstart=0, rsector=0, mounted=0, grant=0, rr pointer=0, state=IDLE.
- Reset mid-transfer aborts the transfer with no done pulse.
- Mount tracking:
  - image_mounted[n] pulse sets mounted[n] when image_size!=0 and clears it when image_size==0.
  - Takes effect the next cycle.
- State machine:
  - IDLE:
    - Search from the rr pointer for the first client n with req_rd[n]|req_wr[n].
    - If mounted[n]=0: pulse done[n] with err=1 next cycle, set rr=n+1, stay IDLE.
    - Otherwise: latch grant=n, op=read if req_rd[n] else write (read wins when both are set; the write is served on a later grant), latch rsector=req_sector[n]; go ISSUE.
  - ISSUE (1 cycle): assert rstart[grant] or wstart[grant]; go WAIT.
  - WAIT:
    - Hold rstart/wstart and rsector stable until rdone.
    - On rdone: clear start next cycle, pulse done[grant] with err=0, set rr=grant+1 (mod 4), go IDLE.
- Gap rule: rstart|wstart stays 0 for at least one full cycle between transfers, so the wrapper sees a fresh rising edge.
- Request deasserted before grant: ignored. Request deasserted after grant: transfer still completes and done still pulses.
- Routing:
  - cl_outen[n] = outen & (state==WAIT) & (grant==n), combinational.
  - cl_outaddr=outaddr; cl_outbyte=outbyte.
  - inbyte = cl_inbyte byte of grant, combinational (zero-latency mux).
- An rdone outside WAIT is ignored.
- rbusy is not used for control; it is exported only for status.

Optional Feature:
- Macro: SD_ARB_TIMEOUT_EN.
- Defined:
  - A 32-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES with no rdone: drop start, pulse done[grant] with err=1, advance rr, go IDLE.
  - If rdone coincides with expiry, rdone wins (err=0).
- Undefined: no counter; WAIT lasts indefinitely.

Decomposition:
- Package sd_arb_pkg holds:
  - state enum: IDLE, ISSUE, WAIT;
  - NUM_CLIENTS, SECTOR_BYTES=512, ADDR_W=9;
  - slot constants: SLOT_FDA=0, SLOT_FDB=1, SLOT_ACSI0=2, SLOT_ACSI1=3.
- One sub-module, sd_arb_rr_pick: combinational 4-way round-robin picker (req vector, pointer → index, valid).

Test Plan:
- Mount slot 0 (image_mounted=0001, image_size=737280) → mounted=0001. req_rd[0] with sector 0x12 → rstart=0001, rsector=0x12. rdone → done=0001, err=0, rstart=0 next cycle.
- req_rd[2] with slot 2 unmounted → done=0100, err=1 within 2 cycles; rstart never asserted.
- Slots 0–3 mounted; all four req_rd held, each dropped on its done → grants in order 0,1,2,3. Check each rdone and done, and a ≥1-cycle rstart=0 gap between grants.
- Slot 1 write: wstart=0010; outaddr sweep 0..511, cl_inbyte[15:8]=~outaddr[7:0] → inbyte matches each cycle; cl_outen stays 0000 for writes with no outen.
- Slot 3 read: 512 outen strobes → cl_outen=1000 only, cl_outbyte=outbyte at every address, including wrap at 511.
- With SD_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100: no rdone → done with err=1 at cycle 100 of WAIT. Repeat with rdone at cycle 100 → err=0.

Source files
------------

// File: rtl/sd_arb_pkg.sv
// sd_arb_pkg: shared constants and types for the SD sector arbiter.
//   - state_t     : arbiter FSM states (IDLE, ISSUE, WAIT)
//   - op_t        : latched transfer direction
//   - NUM_CLIENTS, SECTOR_BYTES, ADDR_W : interface geometry
//   - SLOT_*      : fixed client slot assignment (floppy A/B, ACSI 0/1)
//   - slot_onehot : index -> one-hot slot vector
package sd_arb_pkg;

  localparam int NUM_CLIENTS  = 4;
  localparam int SECTOR_BYTES = 512;
  localparam int ADDR_W       = $clog2(SECTOR_BYTES);

  localparam int SLOT_FDA   = 0;
  localparam int SLOT_FDB   = 1;
  localparam int SLOT_ACSI0 = 2;
  localparam int SLOT_ACSI1 = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  function automatic logic [3:0] slot_onehot(input logic [1:0] idx);
    slot_onehot = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/sd_arb_rr_pick.sv
// sd_arb_rr_pick: combinational 4-way round-robin picker.
// Ports:
//   req   in  4 : request vector
//   ptr   in  2 : index with highest priority this cycle
//   idx   out 2 : first requesting index at or after ptr (wrapping)
//   valid out 1 : any request present
module sd_arb_rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       valid
);

  // rot[k] is the request of the slot k positions after the pointer.
  logic [3:0] rot;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
      assign rot[gi] = req[ptr + 2'(gi)];
    end
  endgenerate

  // Scan from the far end so the nearest request overwrites the result.
  always_comb begin
    idx   = ptr;
    valid = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (rot[k]) begin
        idx   = ptr + 2'(k);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sd_sector_arbiter.sv
// sd_sector_arbiter: shares the SD card wrapper's single sector interface
// among four clients (floppy A/B on slots 0/1, ACSI 0/1 on slots 2/3).
// Round-robin arbitration of read/write requests, per-slot mount tracking,
// byte routing to/from the granted client.
// Optional feature macro: SD_ARB_TIMEOUT_EN (per-transfer watchdog).
// Ports:
//   clk, rstn             : clock, synchronous active-low reset
//   req_rd/req_wr   [4]   : client requests (level, held until done)
//   req_sector      [128] : per-client sector numbers
//   done [4], err         : completion pulse per client, err=1 on failure
//   cl_outen [4]          : per-client read byte strobe
//   cl_outaddr/cl_outbyte : broadcast read address/data
//   cl_inbyte [32]        : per-client write data bytes
//   mounted [4]           : current mount flags
//   image_mounted/size    : mount reports from the wrapper
//   rstart/wstart/rsector : transfer request to the wrapper
//   rbusy, rdone          : wrapper status / completion pulse
//   outen/outaddr/outbyte : wrapper read byte stream
//   inbyte                : write byte to the wrapper
module sd_sector_arbiter
  import sd_arb_pkg::*;
#(
  parameter int          NUM_CLIENTS    = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_CLIENTS-1:0]   req_rd,
  input  logic [NUM_CLIENTS-1:0]   req_wr,
  input  logic [32*NUM_CLIENTS-1:0] req_sector,
  output logic [NUM_CLIENTS-1:0]   done,
  output logic                     err,
  output logic [NUM_CLIENTS-1:0]   cl_outen,
  output logic [ADDR_W-1:0]        cl_outaddr,
  output logic [7:0]               cl_outbyte,
  input  logic [8*NUM_CLIENTS-1:0] cl_inbyte,
  output logic [NUM_CLIENTS-1:0]   mounted,
  input  logic [NUM_CLIENTS-1:0]   image_mounted,
  input  logic [31:0]              image_size,
  output logic [NUM_CLIENTS-1:0]   rstart,
  output logic [NUM_CLIENTS-1:0]   wstart,
  output logic [31:0]              rsector,
  input  logic                     rbusy,
  input  logic                     rdone,
  input  logic                     outen,
  input  logic [ADDR_W-1:0]        outaddr,
  input  logic [7:0]               outbyte,
  output logic [7:0]               inbyte
);

  state_t      state_reg, state_next;
  op_t         op_reg, op_next;
  logic [1:0]  grant_reg, grant_next;
  logic [1:0]  rr_reg, rr_next;
  logic [31:0] rsector_reg, rsector_next;
  logic [3:0]  done_reg, done_next;
  logic        err_reg, err_next;
  logic [3:0]  mounted_reg, mounted_next;

  logic [3:0]  req_any;
  logic [1:0]  pick_idx;
  logic        pick_valid;
  logic [31:0] sector_arr [NUM_CLIENTS];
  logic [7:0]  byte_arr   [NUM_CLIENTS];
  logic [3:0]  start_vec;
  logic        size_nz;

  assign size_nz = (image_size != 32'd0);

  // Per-slot fan-out: mount updates, request qualification, data slicing.
  // A client still sees its request high during the cycle its done pulse is
  // visible, so it is masked out for that cycle to avoid a second service.
  generate
    for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_slot
      assign mounted_next[gi] = image_mounted[gi] ? size_nz : mounted_reg[gi];
      assign req_any[gi]      = (req_rd[gi] | req_wr[gi]) & ~done_reg[gi];
      assign sector_arr[gi]   = req_sector[32*gi +: 32];
      assign byte_arr[gi]     = cl_inbyte[8*gi +: 8];
    end
  endgenerate

  sd_arb_rr_pick u_pick (
    .req   (req_any),
    .ptr   (rr_reg),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

`ifdef SD_ARB_TIMEOUT_EN
  logic [31:0] wait_cnt_reg, wait_cnt_next;
`else
  // The watchdog limit has no effect without the feature.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // rbusy is status only; it never steers the FSM.
  logic unused_status;
  assign unused_status = rbusy;

  always_comb begin
    state_next   = state_reg;
    op_next      = op_reg;
    grant_next   = grant_reg;
    rr_next      = rr_reg;
    rsector_next = rsector_reg;
    done_next    = 4'b0000;
    err_next     = 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
    wait_cnt_next = wait_cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          if (!mounted_reg[pick_idx]) begin
            // Fail fast; the rr pointer still moves past this slot.
            done_next = slot_onehot(pick_idx);
            err_next  = 1'b1;
            rr_next   = pick_idx + 2'd1;
          end else begin
            grant_next   = pick_idx;
            op_next      = req_rd[pick_idx] ? OP_READ : OP_WRITE;
            rsector_next = sector_arr[pick_idx];
            state_next   = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_next = WAIT;
`ifdef SD_ARB_TIMEOUT_EN
        wait_cnt_next = 32'd0;
`endif
      end
      WAIT: begin
`ifdef SD_ARB_TIMEOUT_EN
        wait_cnt_next = wait_cnt_reg + 32'd1;
`endif
        if (rdone) begin
          done_next  = slot_onehot(grant_reg);
          err_next   = 1'b0;
          rr_next    = grant_reg + 2'd1;
          state_next = IDLE;
        end
`ifdef SD_ARB_TIMEOUT_EN
        // Counter holds k-1 during the k-th WAIT cycle.
        else if (wait_cnt_reg == TIMEOUT_CYCLES - 32'd1) begin
          done_next  = slot_onehot(grant_reg);
          err_next   = 1'b1;
          rr_next    = grant_reg + 2'd1;
          state_next = IDLE;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      op_reg      <= OP_READ;
      grant_reg   <= 2'd0;
      rr_reg      <= 2'd0;
      rsector_reg <= 32'd0;
      done_reg    <= 4'b0000;
      err_reg     <= 1'b0;
      mounted_reg <= 4'b0000;
`ifdef SD_ARB_TIMEOUT_EN
      wait_cnt_reg <= 32'd0;
`endif
    end else begin
      state_reg   <= state_next;
      op_reg      <= op_next;
      grant_reg   <= grant_next;
      rr_reg      <= rr_next;
      rsector_reg <= rsector_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      mounted_reg <= mounted_next;
`ifdef SD_ARB_TIMEOUT_EN
      wait_cnt_reg <= wait_cnt_next;
`endif
    end
  end

  // Start is decoded from state, so it drops as soon as the FSM returns to
  // IDLE; the IDLE cycle guarantees a low gap before the next grant's edge.
  assign start_vec = ((state_reg == ISSUE) || (state_reg == WAIT)) ?
                     slot_onehot(grant_reg) : 4'b0000;
  assign rstart    = (op_reg == OP_READ)  ? start_vec : 4'b0000;
  assign wstart    = (op_reg == OP_WRITE) ? start_vec : 4'b0000;
  assign rsector   = rsector_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign mounted   = mounted_reg;

  assign cl_outen   = (outen && (state_reg == WAIT)) ? slot_onehot(grant_reg) : 4'b0000;
  assign cl_outaddr = outaddr;
  assign cl_outbyte = outbyte;
  assign inbyte     = byte_arr[grant_reg];

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Directed testbench for sd_sector_arbiter. Inputs driven on the falling
// edge, outputs sampled on the falling edge (plus #1 for combinational paths).
module tb_sd_sector_arbiter;
  import sd_arb_pkg::*;

  logic         clk;
  logic         rstn;
  logic [3:0]   req_rd, req_wr;
  logic [127:0] req_sector;
  logic [3:0]   done;
  logic         err;
  logic [3:0]   cl_outen;
  logic [8:0]   cl_outaddr;
  logic [7:0]   cl_outbyte;
  logic [31:0]  cl_inbyte;
  logic [3:0]   mounted;
  logic [3:0]   image_mounted;
  logic [31:0]  image_size;
  logic [3:0]   rstart, wstart;
  logic [31:0]  rsector;
  logic         rbusy, rdone, outen;
  logic [8:0]   outaddr;
  logic [7:0]   outbyte;
  logic [7:0]   inbyte;

  int vectors    = 0;
  int miscompares = 0;

  sd_sector_arbiter #(.NUM_CLIENTS(4), .TIMEOUT_CYCLES(32'd100)) dut (
    .clk(clk), .rstn(rstn),
    .req_rd(req_rd), .req_wr(req_wr), .req_sector(req_sector),
    .done(done), .err(err),
    .cl_outen(cl_outen), .cl_outaddr(cl_outaddr), .cl_outbyte(cl_outbyte),
    .cl_inbyte(cl_inbyte), .mounted(mounted),
    .image_mounted(image_mounted), .image_size(image_size),
    .rstart(rstart), .wstart(wstart), .rsector(rsector),
    .rbusy(rbusy), .rdone(rdone),
    .outen(outen), .outaddr(outaddr), .outbyte(outbyte),
    .inbyte(inbyte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic do_mount(input logic [3:0] mask, input logic [31:0] size);
    @(negedge clk);
    image_mounted = mask;
    image_size    = size;
    @(negedge clk);
    image_mounted = 4'b0000;
    image_size    = 32'd0;
  endtask

  // Advances to the first falling edge with any start asserted.
  task automatic wait_start(input int budget, output bit expired);
    expired = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if ((rstart | wstart) != 4'b0000) begin
        expired = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_rd = '0; req_wr = '0; req_sector = '0; cl_inbyte = '0;
    image_mounted = '0; image_size = '0; rbusy = 1'b0; rdone = 1'b0;
    outen = 1'b0; outaddr = '0; outbyte = '0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({done, err, rstart, wstart, mounted, cl_outen} !== 21'd0 || rsector !== 32'd0) begin
      miscompares++;
      $display("FAIL reset: done=%b err=%b rstart=%b wstart=%b mounted=%b cl_outen=%b rsector=%h required all zero",
               done, err, rstart, wstart, mounted, cl_outen, rsector);
    end
    rstn = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_mount_read();
    bit exp;
    do_mount(4'b0001, 32'd737280);
    vectors++;
    if (mounted !== 4'b0001) begin
      miscompares++; $display("FAIL mount0: mounted=%b required 0001", mounted);
    end
    req_sector[31:0] = 32'h12;
    req_rd[0] = 1'b1;
    wait_start(5, exp);
    vectors++;
    if (exp || rstart !== 4'b0001 || wstart !== 4'b0000 || rsector !== 32'h12) begin
      miscompares++;
      $display("FAIL read0_start: rstart=%b wstart=%b rsector=%h required 0001/0000/00000012", rstart, wstart, rsector);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (rstart !== 4'b0001 || done !== 4'b0000) begin
      miscompares++; $display("FAIL read0_hold: rstart=%b done=%b required 0001/0000", rstart, done);
    end
    rdone = 1'b1;
    @(negedge clk);
    rdone = 1'b0;
    vectors++;
    if (done !== 4'b0001 || err !== 1'b0 || rstart !== 4'b0000) begin
      miscompares++; $display("FAIL read0_done: done=%b err=%b rstart=%b required 0001/0/0000", done, err, rstart);
    end
    req_rd[0] = 1'b0;
    @(negedge clk);
    vectors++;
    if (done !== 4'b0000) begin
      miscompares++; $display("FAIL read0_single: done=%b required 0000", done);
    end
    $display("test_mount_read done");
  endtask

  task automatic test_unmounted();
    bit saw_start = 1'b0;
    bit got = 1'b0;
    req_sector[95:64] = 32'h77;
    req_rd[2] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if ((rstart | wstart) != 4'b0000) saw_start = 1'b1;
      if (done != 4'b0000) begin got = 1'b1; break; end
    end
    vectors++;
    if (!got || done !== 4'b0100 || err !== 1'b1 || saw_start) begin
      miscompares++;
      $display("FAIL unmounted: done=%b err=%b start_seen=%0d required 0100/1/0", done, err, saw_start);
    end
    req_rd[2] = 1'b0;
    @(negedge clk);
    vectors++;
    if (done !== 4'b0000 || rstart !== 4'b0000) begin
      miscompares++; $display("FAIL unmounted_after: done=%b rstart=%b required 0000/0000", done, rstart);
    end
    $display("test_unmounted done");
  endtask

  task automatic test_round_robin();
    bit exp;
    logic [3:0] oh;
    do_reset();
    do_mount(4'b1111, 32'd1024);
    for (int i = 0; i < 4; i++) req_sector[32*i +: 32] = 32'h100 + 32'(i);
    req_rd = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      oh = 4'b0001 << i;
      wait_start(6, exp);
      vectors++;
      if (exp || rstart !== oh || rsector !== 32'h100 + 32'(i)) begin
        miscompares++;
        $display("FAIL rr_grant%0d: rstart=%b rsector=%h required %b/%h", i, rstart, rsector, oh, 32'h100 + 32'(i));
      end
      @(negedge clk);
      rdone = 1'b1;
      @(negedge clk);
      rdone = 1'b0;
      vectors++;
      if (done !== oh || err !== 1'b0 || rstart !== 4'b0000) begin
        miscompares++;
        $display("FAIL rr_done%0d: done=%b err=%b rstart=%b required %b/0/0000 (gap)", i, done, err, rstart, oh);
      end
      req_rd[i] = 1'b0;
    end
    $display("test_round_robin done");
  endtask

  task automatic test_write();
    bit exp;
    logic [8:0] a9;
    int bad = 0;
    req_sector[63:32] = 32'h55;
    req_wr[1] = 1'b1;
    wait_start(5, exp);
    vectors++;
    if (exp || wstart !== 4'b0010 || rstart !== 4'b0000) begin
      miscompares++; $display("FAIL write1_start: wstart=%b rstart=%b required 0010/0000", wstart, rstart);
    end
    for (int a = 0; a < 512; a++) begin
      @(negedge clk);
      a9 = 9'(a);
      outaddr = a9;
      cl_inbyte = {8'hA5, 8'hC3, ~a9[7:0], 8'h3C};
      #1;
      vectors++;
      if (inbyte !== ~a9[7:0] || cl_outen !== 4'b0000) begin
        miscompares++;
        if (bad < 4) $display("FAIL write1_byte addr=%0d: inbyte=%h cl_outen=%b required %h/0000", a, inbyte, cl_outen, ~a9[7:0]);
        bad++;
      end
    end
    @(negedge clk);
    rdone = 1'b1;
    @(negedge clk);
    rdone = 1'b0;
    vectors++;
    if (done !== 4'b0010 || err !== 1'b0 || wstart !== 4'b0000) begin
      miscompares++; $display("FAIL write1_done: done=%b err=%b wstart=%b required 0010/0/0000", done, err, wstart);
    end
    req_wr[1] = 1'b0;
    $display("test_write done");
  endtask

  task automatic test_read3();
    bit exp;
    logic [8:0] a9;
    logic [7:0] b;
    int bad = 0;
    req_sector[127:96] = 32'hABCD;
    req_rd[3] = 1'b1;
    wait_start(5, exp);
    vectors++;
    if (exp || rstart !== 4'b1000 || rsector !== 32'hABCD) begin
      miscompares++; $display("FAIL read3_start: rstart=%b rsector=%h required 1000/0000abcd", rstart, rsector);
    end
    for (int a = 0; a <= 512; a++) begin
      @(negedge clk);
      a9 = 9'(a);
      b = a9[7:0] ^ 8'h5A;
      outen = 1'b1;
      outaddr = a9;
      outbyte = b;
      #1;
      vectors++;
      if (cl_outen !== 4'b1000 || cl_outbyte !== b || cl_outaddr !== a9) begin
        miscompares++;
        if (bad < 4) $display("FAIL read3_byte addr=%0d: cl_outen=%b cl_outbyte=%h cl_outaddr=%0d required 1000/%h/%0d",
                              a, cl_outen, cl_outbyte, cl_outaddr, b, a9);
        bad++;
      end
    end
    @(negedge clk);
    outen = 1'b0;
    rdone = 1'b1;
    #1;
    vectors++;
    if (cl_outen !== 4'b0000) begin
      miscompares++; $display("FAIL read3_noen: cl_outen=%b required 0000", cl_outen);
    end
    @(negedge clk);
    rdone = 1'b0;
    vectors++;
    if (done !== 4'b1000 || err !== 1'b0) begin
      miscompares++; $display("FAIL read3_done: done=%b err=%b required 1000/0", done, err);
    end
    req_rd[3] = 1'b0;
    $display("test_read3 done");
  endtask

  task automatic test_misc();
    bit exp;
    @(negedge clk);
    rdone = 1'b1;
    @(negedge clk);
    rdone = 1'b0;
    vectors++;
    if (done !== 4'b0000) begin
      miscompares++; $display("FAIL rdone_idle: done=%b required 0000", done);
    end
    do_mount(4'b1000, 32'd0);
    vectors++;
    if (mounted !== 4'b0111) begin
      miscompares++; $display("FAIL unmount3: mounted=%b required 0111", mounted);
    end
    req_rd[0] = 1'b1;
    req_wr[0] = 1'b1;
    wait_start(5, exp);
    vectors++;
    if (exp || rstart !== 4'b0001 || wstart !== 4'b0000) begin
      miscompares++; $display("FAIL rd_over_wr: rstart=%b wstart=%b required 0001/0000", rstart, wstart);
    end
    @(negedge clk);
    rdone = 1'b1;
    @(negedge clk);
    rdone = 1'b0;
    req_rd[0] = 1'b0;
    req_wr[0] = 1'b0;
    vectors++;
    if (done !== 4'b0001 || err !== 1'b0) begin
      miscompares++; $display("FAIL rd_over_wr_done: done=%b err=%b required 0001/0", done, err);
    end
    @(negedge clk);
    $display("test_misc done");
  endtask

`ifdef SD_ARB_TIMEOUT_EN
  task automatic test_timeout(input bit with_rdone);
    bit exp;
    bit early = 1'b0;
    req_rd[0] = 1'b1;
    wait_start(5, exp);
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (done != 4'b0000 || rstart != 4'b0001) early = 1'b1;
      if (n == 100 && with_rdone) rdone = 1'b1;
    end
    @(negedge clk);
    rdone = 1'b0;
    vectors++;
    if (exp || early || done !== 4'b0001 || err !== !with_rdone || rstart !== 4'b0000) begin
      miscompares++;
      $display("FAIL timeout(rdone=%0d): early=%0d done=%b err=%b rstart=%b required 0/0001/%0d/0000",
               with_rdone, early, done, err, rstart, !with_rdone);
    end
    req_rd[0] = 1'b0;
    @(negedge clk);
    $display("test_timeout rdone=%0d done", with_rdone);
  endtask
`endif

  task automatic test_reset_mid();
    bit exp;
    req_rd[1] = 1'b1;
    wait_start(5, exp);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    vectors++;
    if (exp || rstart !== 4'b0000 || done !== 4'b0000 || mounted !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_mid: rstart=%b done=%b mounted=%b required 0000/0000/0000", rstart, done, mounted);
    end
    rstn = 1'b1;
    req_rd[1] = 1'b0;
    @(negedge clk);
    vectors++;
    if (done !== 4'b0000) begin
      miscompares++; $display("FAIL reset_mid_done: done=%b required 0000", done);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_mount_read();
    test_unmounted();
    test_round_robin();
    test_write();
    test_read3();
    test_misc();
`ifdef SD_ARB_TIMEOUT_EN
    test_timeout(1'b0);
    test_timeout(1'b1);
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
